// File: rtl/adc_sequencer_pkg.sv
// Shared definitions for the oven ADC front-end sequencer: timing defaults,
// channel codes, FSM state encoding and BCD saturation value.
package adc_sequencer_pkg;

  localparam int DEF_WR_CYC  = 4;
  localparam int DEF_RD_CYC  = 3;
  localparam int DEF_TIMEOUT = 255;
  localparam int DEF_GAP_CYC = 16;

  localparam logic [1:0] ADC_CH_TEMP = 2'd0;
  localparam logic [1:0] ADC_CH_SETT = 2'd1;
  localparam logic [1:0] ADC_CH_TIME = 2'd2;

  localparam logic [7:0] BCD_SAT = 8'h99;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RD_HI,
    ST_RD_LO,
    ST_UPDATE
  } adc_state_t;

  // Scan order temp -> set_temp -> set_time -> temp.
  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch == ADC_CH_TIME) ? ADC_CH_TEMP : ch + 2'd1;
  endfunction

endpackage

// File: rtl/adc_sequencer_bin2bcd8.sv
// Sequential shift-add-3 binary to two-digit BCD converter.
// One start pulse converts bin; done pulses with the result 8 cycles later.
// Inputs above 99 give BCD_SAT.
module bin2bcd8
  import adc_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output logic [7:0] bcd
);

  // {tens, units, binary}; a bit carried out of tens means the value exceeded 99
  logic [15:0] sreg;
  logic [15:0] adj;
  logic [3:0]  bit_cnt;
  logic        busy;
  logic        sat;

  // Add 3 to any BCD digit of 5 or more before the next shift.
  always_comb begin
    adj = sreg;
    if (sreg[11:8] >= 4'd5)
      adj[11:8] = sreg[11:8] + 4'd3;
    if (sreg[15:12] >= 4'd5)
      adj[15:12] = sreg[15:12] + 4'd3;
  end

  // Shift engine; sat accumulates every bit that leaves the tens digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      sat     <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sreg    <= {8'd0, bin};
        bit_cnt <= 4'd8;
        busy    <= 1'b1;
        sat     <= 1'b0;
      end else if (busy) begin
        sreg    <= {adj[14:0], 1'b0};
        bit_cnt <= bit_cnt - 4'd1;
        sat     <= sat | adj[15];
        if (bit_cnt == 4'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
          bcd  <= (sat | adj[15]) ? BCD_SAT : adj[14:7];
        end
      end
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// Front-end sequencer for the 4-bit-bus oven ADC. Scans temperature,
// temperature set-point and time set-point channels, reading each 8-bit
// result as two nibbles, and publishes filtered values to the oven FSM.
//
//  state  | meaning
//  IDLE   | inter-conversion gap, GAP_CYC cycles
//  START  | adc_wr_n low for WR_CYC cycles
//  WAIT   | wait for synced EOC falling edge, abort after TIMEOUT cycles
//  RD_HI  | adc_rd_n low, high nibble selected, latch after RD_CYC cycles
//  RD_LO  | one cycle with adc_rd_n high, then low nibble read like RD_HI
//  UPDATE | assemble sample and write the channel's output register
module adc_sequencer
  import adc_sequencer_pkg::*;
#(
  parameter int WR_CYC  = DEF_WR_CYC,
  parameter int RD_CYC  = DEF_RD_CYC,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adc_int_n,
  input  logic [3:0] adc_data,
  output logic       adc_wr_n,
  output logic       adc_rd_n,
  output logic       adc_nib,
  output logic [1:0] adc_ch,
  output logic [7:0] current_temp,
  output logic [7:0] set_temp,
  output logic [3:0] set_time,
  output logic [7:0] digit_adc,
  output logic       sample_valid,
  output logic       adc_err
);

  // Down-counter reload values: a state lasts (load + 1) cycles.
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYC - 1);
  localparam logic [7:0] WR_LOAD    = 8'(WR_CYC - 1);
  localparam logic [7:0] TO_LOAD    = 8'(TIMEOUT - 1);
  localparam logic [7:0] RD_LOAD    = 8'(RD_CYC - 1);
  // RD_LO spends its first cycle with adc_rd_n still high.
  localparam logic [7:0] RD_LO_LOAD = 8'(RD_CYC);

  adc_state_t  state;
  logic [7:0]  cnt;
  logic        int_s1, int_s2, int_s3;
  logic        int_fall;
  logic [3:0]  nib_hi, nib_lo;
  logic [7:0]  sample;
  logic [9:0]  acc;
  logic [9:0]  acc_sum;
  logic [1:0]  acc_cnt;
  logic [3:0]  time_clamped;
  logic        bcd_start;
  logic        bcd_done;
  logic [7:0]  bcd_out;

  assign int_fall     = int_s3 & ~int_s2;
  assign sample       = {nib_hi, nib_lo};
  assign acc_sum      = acc + {2'b00, sample};
  assign time_clamped = (sample[7:4] == 4'd0) ? 4'd1 : sample[7:4];

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_s1 <= 1'b1;
      int_s2 <= 1'b1;
      int_s3 <= 1'b1;
    end else begin
      int_s1 <= adc_int_n;
      int_s2 <= int_s1;
      int_s3 <= int_s2;
    end
  end

  // Conversion FSM with shared down-counter, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= GAP_LOAD;
      adc_wr_n     <= 1'b1;
      adc_rd_n     <= 1'b1;
      adc_nib      <= 1'b1;
      adc_ch       <= ADC_CH_TEMP;
      nib_hi       <= '0;
      nib_lo       <= '0;
      acc          <= '0;
      acc_cnt      <= '0;
      current_temp <= '0;
      set_temp     <= '0;
      set_time     <= 4'd1;
      digit_adc    <= '0;
      sample_valid <= 1'b0;
      adc_err      <= 1'b0;
      bcd_start    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      bcd_start    <= 1'b0;
      if (bcd_done)
        digit_adc <= bcd_out;

      case (state)
        ST_IDLE: begin
          if (cnt == 8'd0) begin
            state    <= ST_START;
            cnt      <= WR_LOAD;
            adc_wr_n <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        ST_START: begin
          if (cnt == 8'd0) begin
            state    <= ST_WAIT;
            cnt      <= TO_LOAD;
            adc_wr_n <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        ST_WAIT: begin
          if (int_fall) begin
            state    <= ST_RD_HI;
            cnt      <= RD_LOAD;
            adc_rd_n <= 1'b0;
            adc_nib  <= 1'b1;
          end else if (cnt == 8'd0) begin
            state   <= ST_IDLE;
            cnt     <= GAP_LOAD;
            adc_err <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        ST_RD_HI: begin
          if (cnt == 8'd0) begin
            nib_hi   <= adc_data;
            state    <= ST_RD_LO;
            cnt      <= RD_LO_LOAD;
            adc_rd_n <= 1'b1;
            adc_nib  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        ST_RD_LO: begin
          if (cnt == 8'd0) begin
            nib_lo   <= adc_data;
            state    <= ST_UPDATE;
            adc_rd_n <= 1'b1;
            adc_nib  <= 1'b1;
          end else begin
            adc_rd_n <= 1'b0;
            cnt      <= cnt - 8'd1;
          end
        end

        ST_UPDATE: begin
          adc_err <= 1'b0;
          case (adc_ch)
            ADC_CH_TEMP: begin
              if (acc_cnt == 2'd3) begin
                current_temp <= acc_sum[9:2];
                acc          <= '0;
                acc_cnt      <= '0;
                sample_valid <= 1'b1;
                bcd_start    <= 1'b1;
              end else begin
                acc     <= acc_sum;
                acc_cnt <= acc_cnt + 2'd1;
              end
            end
            ADC_CH_SETT: begin
              set_temp     <= sample;
              sample_valid <= 1'b1;
            end
            ADC_CH_TIME: begin
              set_time     <= time_clamped;
              sample_valid <= 1'b1;
            end
            default: ;
          endcase
          adc_ch <= next_ch(adc_ch);
          state  <= ST_IDLE;
          cnt    <= GAP_LOAD;
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= GAP_LOAD;
        end
      endcase
    end
  end

  bin2bcd8 u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start),
    .bin   (current_temp),
    .done  (bcd_done),
    .bcd   (bcd_out)
  );

endmodule

// File: tb/tb_adc_sequencer.sv
// Bench for adc_sequencer: behavioural ADC model plus scoreboard of expected
// output-register updates, driven by one task per scenario.
module tb_adc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       adc_int_n;
  logic [3:0] adc_data;
  logic       adc_wr_n, adc_rd_n, adc_nib;
  logic [1:0] adc_ch;
  logic [7:0] current_temp, set_temp, digit_adc;
  logic [3:0] set_time;
  logic       sample_valid, adc_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         ch;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] q0[$], q1[$], q2[$];
  logic [7:0] def_val[3];

  // ADC model state
  int         exp_ch    = 0;
  int         acc_sum   = 0;
  int         acc_n     = 0;
  bit         int_en    = 1'b1;
  bit         pending   = 1'b0;
  int         spur_cnt  = 0;
  int         answered  = 0;
  int         countdown = -1;
  int         int_low   = 0;
  logic [7:0] cur_val   = 8'h00;
  logic       wr_prev   = 1'b1;
  exp_t       e;
  logic [7:0] got;
  logic [7:0] tclamp;

  always #5 clk = ~clk;

  adc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .adc_int_n    (adc_int_n),
    .adc_data     (adc_data),
    .adc_wr_n     (adc_wr_n),
    .adc_rd_n     (adc_rd_n),
    .adc_nib      (adc_nib),
    .adc_ch       (adc_ch),
    .current_temp (current_temp),
    .set_temp     (set_temp),
    .set_time     (set_time),
    .digit_adc    (digit_adc),
    .sample_valid (sample_valid),
    .adc_err      (adc_err)
  );

  // ADC model and scoreboard consumer, all activity on the falling edge
  initial begin
    adc_int_n = 1'b1;
    adc_data  = 4'h0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (sample_valid === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_valid got=1 required=0 at %0t", $time);
          end else begin
            e = sb.pop_front();
            case (e.ch)
              0:       got = current_temp;
              1:       got = set_temp;
              default: got = {4'h0, set_time};
            endcase
            if (got !== e.val) begin
              failures++;
              $display("FAIL sb_ch%0d got=%h required=%h at %0t", e.ch, got, e.val, $time);
            end
          end
        end

        if (adc_wr_n === 1'b0 && wr_prev === 1'b1) begin
          checks++;
          if (adc_ch !== 2'(exp_ch)) begin
            failures++;
            $display("FAIL chan_order got=%0d required=%0d", adc_ch, exp_ch);
          end
          if (int_en) begin
            if (exp_ch == 0) cur_val = (q0.size() > 0) ? q0.pop_front() : def_val[0];
            else if (exp_ch == 1) cur_val = (q1.size() > 0) ? q1.pop_front() : def_val[1];
            else cur_val = (q2.size() > 0) ? q2.pop_front() : def_val[2];
            if (exp_ch == 0) begin
              acc_sum += int'(cur_val);
              acc_n++;
              if (acc_n == 4) begin
                sb.push_back('{0, 8'(acc_sum >> 2)});
                acc_sum = 0;
                acc_n   = 0;
              end
            end else if (exp_ch == 1) begin
              sb.push_back('{1, cur_val});
            end else begin
              tclamp = (cur_val[7:4] == 4'd0) ? 8'd1 : {4'h0, cur_val[7:4]};
              sb.push_back('{2, tclamp});
            end
            exp_ch  = (exp_ch + 1) % 3;
            pending = 1'b1;
          end else begin
            pending = 1'b0;
          end
        end

        if (adc_wr_n === 1'b1 && wr_prev === 1'b0 && pending) begin
          countdown = 10;
          pending   = 1'b0;
        end else if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            int_low   = 4;
            answered++;
            countdown = -1;
          end
        end
        wr_prev = adc_wr_n;

        adc_int_n = !(int_low > 0 || spur_cnt > 0);
        if (int_low > 0)  int_low--;
        if (spur_cnt > 0) spur_cnt--;
        adc_data = (adc_rd_n === 1'b0) ? (adc_nib ? cur_val[7:4] : cur_val[3:0]) : 4'h0;
      end else begin
        adc_int_n = 1'b1;
      end
    end
  end

  task automatic run_conv(input int n);
    int target = answered + n;
    int budget = n * 120;
    while (answered < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (answered < target) begin
      failures++;
      $display("FAIL run_conv_budget answered=%0d required=%0d", answered, target);
    end
    repeat (15) @(negedge clk);
  endtask

  task automatic clear_model();
    sb.delete();
    q0.delete();
    q1.delete();
    q2.delete();
    exp_ch    = 0;
    acc_sum   = 0;
    acc_n     = 0;
    countdown = -1;
    int_low   = 0;
    spur_cnt  = 0;
    pending   = 1'b0;
    wr_prev   = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    logic [31:0] got_v [10];
    logic [31:0] req_v [10];
    string       nm    [10];
    got_v = '{adc_wr_n, adc_rd_n, adc_nib, adc_ch, current_temp, set_temp,
              set_time, digit_adc, sample_valid, adc_err};
    req_v = '{1, 1, 1, 0, 0, 0, 1, 0, 0, 0};
    nm    = '{"wr_n", "rd_n", "nib", "ch", "current_temp", "set_temp",
              "set_time", "digit_adc", "sample_valid", "adc_err"};
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got_v[i] !== req_v[i]) begin
        failures++;
        $display("FAIL %s_%s got=%0h required=%0h", tag, nm[i], got_v[i], req_v[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
  endtask

  task automatic test_read_timing();
    int   budget = 200;
    int   hi_len = 0, gap_len = 0, lo_len = 0;
    logic hi_nib, lo_nib;
    while (adc_rd_n !== 1'b0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    hi_nib = adc_nib;
    while (adc_rd_n === 1'b0 && hi_len < 10) begin hi_len++; @(negedge clk); end
    while (adc_rd_n === 1'b1 && gap_len < 10) begin gap_len++; @(negedge clk); end
    lo_nib = adc_nib;
    while (adc_rd_n === 1'b0 && lo_len < 10) begin lo_len++; @(negedge clk); end
    checks++;
    if (hi_len != 3) begin failures++; $display("FAIL rd_hi_len got=%0d required=3", hi_len); end
    checks++;
    if (hi_nib !== 1'b1) begin failures++; $display("FAIL rd_hi_nib got=%b required=1", hi_nib); end
    checks++;
    if (gap_len != 1) begin failures++; $display("FAIL rd_gap_len got=%0d required=1", gap_len); end
    checks++;
    if (lo_len != 3) begin failures++; $display("FAIL rd_lo_len got=%0d required=3", lo_len); end
    checks++;
    if (lo_nib !== 1'b0) begin failures++; $display("FAIL rd_lo_nib got=%b required=0", lo_nib); end
  endtask

  task automatic test_avg_const();
    run_conv(9);
    checks++;
    if (current_temp !== 8'd60) begin
      failures++;
      $display("FAIL avg_const_temp got=%0d required=60", current_temp);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (digit_adc !== 8'h60) begin
      failures++;
      $display("FAIL avg_const_bcd got=%h required=60", digit_adc);
    end
    checks++;
    if (set_temp !== 8'h55) begin failures++; $display("FAIL avg_const_set_temp got=%h required=55", set_temp); end
    checks++;
    if (set_time !== 4'd10) begin failures++; $display("FAIL avg_const_set_time got=%0d required=10", set_time); end
  endtask

  task automatic test_avg_mixed();
    q0.push_back(8'd10); q0.push_back(8'd20); q0.push_back(8'd30); q0.push_back(8'd41);
    q1.push_back(8'h00); q1.push_back(8'hFF); q1.push_back(8'h7A); q1.push_back(8'h81);
    q2.push_back(8'h1F); q2.push_back(8'h00); q2.push_back(8'hF0); q2.push_back(8'h0F);
    run_conv(12);
    checks++;
    if (current_temp !== 8'd25) begin failures++; $display("FAIL avg_mixed_temp got=%0d required=25", current_temp); end
    repeat (10) @(negedge clk);
    checks++;
    if (digit_adc !== 8'h25) begin failures++; $display("FAIL avg_mixed_bcd got=%h required=25", digit_adc); end
    checks++;
    if (set_time !== 4'd1) begin failures++; $display("FAIL avg_mixed_set_time got=%0d required=1", set_time); end
    checks++;
    if (set_temp !== 8'h81) begin failures++; $display("FAIL avg_mixed_set_temp got=%h required=81", set_temp); end
  endtask

  task automatic test_saturate();
    repeat (4) q0.push_back(8'hC8);
    run_conv(12);
    checks++;
    if (current_temp !== 8'd200) begin failures++; $display("FAIL sat_temp got=%0d required=200", current_temp); end
    repeat (10) @(negedge clk);
    checks++;
    if (digit_adc !== 8'h99) begin failures++; $display("FAIL sat_bcd got=%h required=99", digit_adc); end
    checks++;
    if (set_time !== 4'd10) begin failures++; $display("FAIL sat_set_time got=%0d required=10", set_time); end
  endtask

  task automatic test_timeout();
    int budget = 100;
    int ch_before;
    int_en    = 1'b0;
    ch_before = exp_ch;
    while (adc_wr_n !== 1'b0 && budget > 0) begin @(negedge clk); budget--; end
    while (adc_wr_n !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
    checks++;
    if (budget == 0) begin failures++; $display("FAIL timeout_start_budget got=0 required=>0"); end
    repeat (250) @(negedge clk);
    checks++;
    if (adc_err !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b required=0", adc_err); end
    repeat (6) @(negedge clk);
    checks++;
    if (adc_err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b required=1", adc_err); end
    int_en = 1'b1;
    checks++;
    if (adc_ch !== 2'(ch_before)) begin failures++; $display("FAIL timeout_ch got=%0d required=%0d", adc_ch, ch_before); end
    checks++;
    if (current_temp !== 8'd200 || set_temp !== 8'h55 || set_time !== 4'd10) begin
      failures++;
      $display("FAIL timeout_outputs got=%h/%h/%h required=c8/55/a", current_temp, set_temp, set_time);
    end
    run_conv(1);
    checks++;
    if (adc_err !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b required=0", adc_err); end
  endtask

  task automatic test_reset_mid();
    int budget = 200;
    while (!(adc_rd_n === 1'b0 && adc_nib === 1'b0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (budget == 0) begin failures++; $display("FAIL reset_mid_rd_lo_budget got=0 required=>0"); end
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("reset_mid");
    rst = 1'b0;
    #1;
    clear_model();
  endtask

  task automatic test_spurious();
    int budget = 60;
    int rd_seen = 0;
    repeat (3) @(negedge clk);
    spur_cnt = 2;
    repeat (10) begin
      @(negedge clk);
      if (adc_rd_n === 1'b0) rd_seen++;
    end
    checks++;
    if (rd_seen != 0) begin failures++; $display("FAIL spur_idle_read got=%0d required=0", rd_seen); end
    while (adc_wr_n !== 1'b0 && budget > 0) begin @(negedge clk); budget--; end
    spur_cnt = 2;
    repeat (5) begin
      @(negedge clk);
      if (adc_rd_n === 1'b0) rd_seen++;
    end
    checks++;
    if (rd_seen != 0) begin failures++; $display("FAIL spur_start_read got=%0d required=0", rd_seen); end
    run_conv(4);
    checks++;
    if (current_temp !== 8'd0) begin failures++; $display("FAIL spur_partial_temp got=%0d required=0", current_temp); end
    checks++;
    if (set_temp !== 8'h55 || set_time !== 4'd10) begin
      failures++;
      $display("FAIL spur_outputs got=%h/%h required=55/a", set_temp, set_time);
    end
  endtask

  initial begin
    def_val[0] = 8'h3C;
    def_val[1] = 8'h55;
    def_val[2] = 8'hA0;
    test_reset();
    test_read_timing();
    test_avg_const();
    test_avg_mixed();
    test_saturate();
    test_timeout();
    test_reset_mid();
    test_spurious();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
